// File: rtl/cpu5_pkg.sv
// Shared constants and types for the 5-bit CPU control sequencer.
package cpu5_pkg;

  localparam logic [3:0] OPC_JGT  = 4'b0011;
  localparam logic [3:0] OPC_CMPI = 4'b0100;
  localparam logic [3:0] OPC_NOP  = 4'b1000;
  localparam logic [3:0] OPC_LDI  = 4'b1110;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [1:0] ADDR_PC  = 2'b00;
  localparam logic [1:0] ADDR_PTR = 2'b01;
  localparam logic [1:0] ADDR_MAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_IND_PTR  = 3'd4,
    ST_IND_DATA = 3'd5,
    ST_HALT     = 3'd6
  } state_t;

  // Per-instruction class signals; the FSM qualifies them with its state.
  typedef struct packed {
    logic [1:0] op;
    logic       imm_sel;
    logic       reg_en;
    logic       flag_en;
    logic       jmp_cond;
    logic       ld;
  } dec_t;

endpackage

// File: rtl/cpu5_op_decode.sv
// Combinational opcode-class decode of the latched IR plus the JGT flag test.
module cpu5_op_decode
  import cpu5_pkg::*;
(
  input  logic [3:0] i_ir,
  input  logic       i_zf,
  input  logic       i_sf,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_ir == OPC_JGT) begin
      o_dec.jmp_cond = ~i_zf & ~i_sf;
    end else if (i_ir[3:2] == 2'b00) begin
      o_dec.op      = i_ir[1:0];
      o_dec.flag_en = 1'b1;
    end else if (i_ir == OPC_CMPI) begin
      o_dec.op      = i_ir[1:0];
      o_dec.imm_sel = 1'b1;
      o_dec.flag_en = 1'b1;
    end else if (i_ir[3:2] == 2'b01) begin
      o_dec.op      = i_ir[1:0];
      o_dec.imm_sel = 1'b1;
      o_dec.reg_en  = 1'b1;
    end else if (i_ir == OPC_NOP || i_ir == OPC_HALT) begin
      o_dec = '0;
    end else if (i_ir == OPC_LDI) begin
      o_dec.ld = 1'b1;
    end else begin
      o_dec.op     = i_ir[1:0];
      o_dec.reg_en = 1'b1;
    end
  end

endmodule

// File: rtl/cpu5_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with memory handshake and LD-indirect.
module cpu5_sequencer
  import cpu5_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       ZF,
  input  logic       SF,
  input  logic       CF,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic [1:0] addr_sel,
  output logic       ir_en,
  output logic       pc_inc,
  output logic       mar_en,
  output logic [1:0] OP,
  output logic       REG_EN,
  output logic       FLAG_EN,
  output logic       IMM_SEL,
  output logic       JMP_SEL,
  output logic       LD_SEL,
  output logic       halted,
  output logic       retire
);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_ir;
  dec_t       w_dec;
  logic       w_exec;
  logic       w_unused;

  // CF is reserved for future conditional opcodes.
  assign w_unused = CF;

  cpu5_op_decode u_decode (
    .i_ir  (r_ir),
    .i_zf  (ZF),
    .i_sf  (SF),
    .o_dec (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ir    <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      if (ir_en) r_ir <= opcode;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (run) w_state_next = ST_FETCH;
      ST_FETCH:    if (mem_ready) w_state_next = ST_DECODE;
      ST_DECODE: begin
        if (r_ir == OPC_HALT)  w_state_next = ST_HALT;
        else if (w_dec.ld)     w_state_next = ST_IND_PTR;
        else                   w_state_next = ST_EXEC;
      end
      ST_EXEC:     w_state_next = run ? ST_FETCH : ST_IDLE;
      ST_IND_PTR:  if (mem_ready) w_state_next = ST_IND_DATA;
      ST_IND_DATA: if (mem_ready) w_state_next = run ? ST_FETCH : ST_IDLE;
      ST_HALT:     w_state_next = ST_HALT;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  assign w_exec = (r_state == ST_EXEC);

  always_comb begin
    mem_req  = 1'b0;
    addr_sel = ADDR_PC;
    ir_en    = 1'b0;
    pc_inc   = 1'b0;
    mar_en   = 1'b0;
    LD_SEL   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ready;
        pc_inc  = mem_ready;
      end
      ST_IND_PTR: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_PTR;
        mar_en   = mem_ready;
      end
      ST_IND_DATA: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_MAR;
        LD_SEL   = mem_ready;
      end
      default: ;
    endcase
  end

  // The indirect load's write-back shares REG_EN and retire with EXEC.
  assign OP      = w_exec ? w_dec.op : 2'b00;
  assign IMM_SEL = w_exec & w_dec.imm_sel;
  assign FLAG_EN = w_exec & w_dec.flag_en;
  assign JMP_SEL = w_exec & w_dec.jmp_cond;
  assign REG_EN  = (w_exec & w_dec.reg_en) | LD_SEL;
  assign retire  = w_exec | LD_SEL;
  assign halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu5_sequencer.sv
// Directed bench: walks each instruction class cycle by cycle against hand-built strobe vectors.
module tb_cpu5_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       ZF, SF, CF;
  logic       mem_ready;
  logic       mem_req;
  logic [1:0] addr_sel;
  logic       ir_en, pc_inc, mar_en;
  logic [1:0] OP;
  logic       REG_EN, FLAG_EN, IMM_SEL, JMP_SEL, LD_SEL, halted, retire;

  int total = 0;
  int bad   = 0;

  // Output vector bit layout:
  // {mem_req, addr_sel[1:0], ir_en, pc_inc, mar_en, OP[1:0], REG_EN, FLAG_EN, IMM_SEL, JMP_SEL, LD_SEL, halted, retire}
  localparam logic [14:0] B_REQ = 15'h4000;
  localparam logic [14:0] A_PTR = 15'h1000;
  localparam logic [14:0] A_MAR = 15'h2000;
  localparam logic [14:0] B_IR  = 15'h0800;
  localparam logic [14:0] B_PC  = 15'h0400;
  localparam logic [14:0] B_MAR = 15'h0200;
  localparam logic [14:0] OP1   = 15'h0080;
  localparam logic [14:0] B_REG = 15'h0040;
  localparam logic [14:0] B_FLG = 15'h0020;
  localparam logic [14:0] B_IMM = 15'h0010;
  localparam logic [14:0] B_JMP = 15'h0008;
  localparam logic [14:0] B_LD  = 15'h0004;
  localparam logic [14:0] B_HLT = 15'h0002;
  localparam logic [14:0] B_RET = 15'h0001;
  localparam logic [14:0] V_FETCH = B_REQ | B_IR | B_PC;

  wire [14:0] outs = {mem_req, addr_sel, ir_en, pc_inc, mar_en, OP,
                      REG_EN, FLAG_EN, IMM_SEL, JMP_SEL, LD_SEL, halted, retire};

  cpu5_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .ZF        (ZF),
    .SF        (SF),
    .CF        (CF),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .addr_sel  (addr_sel),
    .ir_en     (ir_en),
    .pc_inc    (pc_inc),
    .mar_en    (mar_en),
    .OP        (OP),
    .REG_EN    (REG_EN),
    .FLAG_EN   (FLAG_EN),
    .IMM_SEL   (IMM_SEL),
    .JMP_SEL   (JMP_SEL),
    .LD_SEL    (LD_SEL),
    .halted    (halted),
    .retire    (retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s outs=%h", tag, got);
    end
  endtask

  // Inputs are changed just after the rising edge; outputs are checked mid-cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input string tag, input logic [14:0] exp);
    @(negedge clk);
    chk(tag, outs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 4'b0000;
    ZF = 1'b0; SF = 1'b0; CF = 1'b0; mem_ready = 1'b0;
    at("reset", 15'h0000);
    nxt(); rst_n = 1'b1;
    at("idle_ready_ignored", 15'h0000);

    // Register ALU op 1001
    nxt(); run = 1'b1; mem_ready = 1'b1; opcode = 4'b1001;
    at("idle_run", 15'h0000);
    nxt(); at("alu_fetch", V_FETCH);
    nxt(); at("alu_decode", 15'h0000);
    nxt(); at("alu_exec", B_REG | OP1 | B_RET);

    // JGT taken
    opcode = 4'b0011;
    nxt(); at("jgt_fetch", V_FETCH);
    nxt(); at("jgt_decode", 15'h0000);
    nxt(); at("jgt_taken", B_JMP | B_RET);

    // JGT not taken (SF=1)
    nxt(); at("jgt2_fetch", V_FETCH);
    nxt(); SF = 1'b1; at("jgt2_decode", 15'h0000);
    nxt(); at("jgt_not_taken", B_RET);

    // LD indirect with two wait cycles on the pointer access
    SF = 1'b0; opcode = 4'b1110;
    nxt(); at("ldi_fetch", V_FETCH);
    nxt(); at("ldi_decode", 15'h0000);
    nxt(); mem_ready = 1'b0; at("ldi_ptr_wait1", B_REQ | A_PTR);
    nxt(); at("ldi_ptr_wait2", B_REQ | A_PTR);
    nxt(); mem_ready = 1'b1; at("ldi_ptr_done", B_REQ | A_PTR | B_MAR);
    nxt(); at("ldi_data", B_REQ | A_MAR | B_REG | B_LD | B_RET);

    // Compare immediate
    opcode = 4'b0100;
    nxt(); at("cmpi_fetch", V_FETCH);
    nxt(); at("cmpi_decode", 15'h0000);
    nxt(); at("cmpi_exec", B_IMM | B_FLG | B_RET);

    // NOP, dropping run at completion
    opcode = 4'b1000;
    nxt(); at("nop_fetch", V_FETCH);
    nxt(); run = 1'b0; at("nop_decode", 15'h0000);
    nxt(); at("nop_exec", B_RET);
    nxt(); at("idle_after_run_drop", 15'h0000);

    // LD indirect, reset during a data wait
    run = 1'b1; opcode = 4'b1110;
    nxt(); at("ldi2_fetch", V_FETCH);
    nxt(); at("ldi2_decode", 15'h0000);
    nxt(); at("ldi2_ptr", B_REQ | A_PTR | B_MAR);
    nxt(); mem_ready = 1'b0; at("ldi2_data_wait", B_REQ | A_MAR);
    #2 rst_n = 1'b0; run = 1'b0;
    #1 chk("async_reset", outs, 15'h0000);
    nxt(); rst_n = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at($sformatf("idle_post_reset%0d", i), 15'h0000);
      nxt();
    end

    // HALT
    run = 1'b1; opcode = 4'b1111;
    at("halt_idle", 15'h0000);
    nxt(); at("halt_fetch", V_FETCH);
    nxt(); at("halt_decode", 15'h0000);
    for (int i = 0; i < 10; i++) begin
      nxt(); at($sformatf("halted%0d", i), B_HLT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
